// File: rtl/pagerank_pkg.sv
// Shared constants for the PageRank contribution accumulator: default widths,
// FSM state encoding and the saturation ceiling.
package pagerank_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int FRAC_W_DEF  = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int NUM_DIV_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

  localparam logic [DATA_W_DEF-1:0] SAT_MAX = '1;
endpackage

// File: rtl/pr_seq_divider.sv
// One divider lane: radix-2 restoring unsigned division, DATA_W busy cycles,
// then holds the quotient with q_valid until acknowledged.
module pr_seq_divider
  import pagerank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  input  logic              i_ack,
  output logic [DATA_W-1:0] o_quotient,
  output logic              o_q_valid,
  output logic              o_busy
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_rem, r_quot, r_div;
  logic [CW-1:0]     r_cnt;
  logic              r_busy, r_qv;
  logic [DATA_W:0]   w_sh, w_diff;
  logic              w_ge;

  // Partial remainder needs one extra bit before the trial subtract.
  assign w_sh   = {r_rem, r_quot[DATA_W-1]};
  assign w_ge   = w_sh >= {1'b0, r_div};
  assign w_diff = w_sh - {1'b0, r_div};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_qv   <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_div  <= i_divisor;
      r_cnt  <= CW'(DATA_W);
      r_busy <= 1'b1;
      r_qv   <= 1'b0;
    end else if (r_busy) begin
      r_rem  <= w_ge ? w_diff[DATA_W-1:0] : w_sh[DATA_W-1:0];
      r_quot <= {r_quot[DATA_W-2:0], w_ge};
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_qv   <= 1'b1;
      end
    end else if (i_ack) begin
      r_qv <= 1'b0;
    end
  end

  assign o_quotient = r_quot;
  assign o_q_valid  = r_qv;
  assign o_busy     = r_busy;
endmodule

// File: rtl/pagerank_contrib_accum.sv
// Streams (rank, degree) pairs into NUM_DIV divider lanes and accumulates the
// quotients onto an initial sum with saturation and dangling-node counting.
module pagerank_contrib_accum
  import pagerank_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_DIV = NUM_DIV_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_in_count,
  input  logic [DATA_W-1:0] i_init_sum,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_rank,
  input  logic [DATA_W-1:0] i_in_deg,
  output logic [DATA_W-1:0] o_result,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [CNT_W-1:0]  o_dangling_cnt
);
  state_e                         r_state, w_next;
  logic [CNT_W-1:0]               r_count, r_accepted, r_dangling;
  logic [DATA_W-1:0]              r_acc, r_result;
  logic                           r_done, r_overflow;
  logic [NUM_DIV-1:0]             w_lane_busy, w_lane_qv, w_free, w_issue, w_ack;
  logic [NUM_DIV-1:0][DATA_W-1:0] w_lane_q;
  logic [DATA_W-1:0]              w_sel_q;
  logic [DATA_W:0]                w_sum;
  logic                           w_found_free, w_found_q, w_in_ready, w_accept;
  logic                           w_deg_nz, w_all_idle, w_start_ok;

  assign w_free     = ~w_lane_busy & ~w_lane_qv;
  assign w_all_idle = ~|(w_lane_busy | w_lane_qv);
  assign w_deg_nz   = |i_in_deg;
  // Ready never looks at the data, so zero-degree pairs also wait for a free lane.
  assign w_in_ready = (r_state == LOAD) && (r_accepted < r_count) && (|w_free);
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_start_ok = i_start && (r_state == IDLE || r_state == DONE);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_sel_q};

  // Lowest-index free lane takes the issue; lowest-index finished lane is drained.
  always_comb begin
    w_issue      = '0;
    w_ack        = '0;
    w_sel_q      = '0;
    w_found_free = 1'b0;
    w_found_q    = 1'b0;
    for (int i = 0; i < NUM_DIV; i++) begin
      if (w_free[i] && !w_found_free) begin
        w_issue[i]   = w_accept & w_deg_nz;
        w_found_free = 1'b1;
      end
      if (w_lane_qv[i] && !w_found_q) begin
        w_ack[i]  = 1'b1;
        w_sel_q   = w_lane_q[i];
        w_found_q = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIV; g++) begin : g_lane
    pr_seq_divider #(.DATA_W(DATA_W)) u_div (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_start    (w_issue[g]),
      .i_dividend (i_in_rank),
      .i_divisor  (i_in_deg),
      .i_ack      (w_ack[g]),
      .o_quotient (w_lane_q[g]),
      .o_q_valid  (w_lane_qv[g]),
      .o_busy     (w_lane_busy[g])
    );
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (i_start) w_next = LOAD;
      LOAD:       if (r_accepted == r_count) w_next = DRAIN;
      DRAIN:      if (w_all_idle) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count    <= '0;
      r_accepted <= '0;
      r_dangling <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_count    <= i_in_count;
      r_accepted <= '0;
      r_dangling <= '0;
      r_acc      <= i_init_sum;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_accepted <= r_accepted + CNT_W'(1);
        if (!w_deg_nz) r_dangling <= r_dangling + CNT_W'(1);
      end
      if (w_found_q) begin
        if (w_sum[DATA_W]) begin
          r_acc      <= '1;
          r_overflow <= 1'b1;
        end else begin
          r_acc <= w_sum[DATA_W-1:0];
        end
      end
      if (r_state == DRAIN && w_all_idle) begin
        r_result <= r_acc;
        r_done   <= 1'b1;
      end
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_result       = r_result;
  assign o_done         = r_done;
  assign o_busy         = (r_state == LOAD) || (r_state == DRAIN);
  assign o_overflow     = r_overflow;
  assign o_dangling_cnt = r_dangling;
endmodule

// File: tb/tb_pagerank_contrib_accum.sv
// Self-checking bench: table of jobs with expected results queued at start and
// compared when done rises, plus hand-written reset and latency sequences.
module tb_pagerank_contrib_accum;
  import pagerank_pkg::*;
  localparam int DW = 32;
  localparam int ND = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, done, busy, overflow;
  logic [CW-1:0] in_count, dangling_cnt;
  logic [DW-1:0] init_sum, in_rank, in_deg, result;

  always #5 clk = ~clk;

  pagerank_contrib_accum #(.DATA_W(DW), .NUM_DIV(ND), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_in_count(in_count),
    .i_init_sum(init_sum), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_rank(in_rank), .i_in_deg(in_deg), .o_result(result), .o_done(done),
    .o_busy(busy), .o_overflow(overflow), .o_dangling_cnt(dangling_cnt)
  );

  typedef struct {
    int                  n;
    logic [DW-1:0]       init;
    logic [15:0][DW-1:0] rank;
    logic [15:0][DW-1:0] deg;
    logic [DW-1:0]       exp_res;
    logic                exp_ovf;
    int                  exp_dang;
    logic                exp_stall;
  } vec_t;

  typedef struct {
    logic [DW-1:0] res;
    logic          ovf;
    int            dang;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[4];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.n = 0; v.init = '0; v.rank = '0; v.deg = '0;
    v.exp_res = '0; v.exp_ovf = 1'b0; v.exp_dang = 0; v.exp_stall = 1'b0;
    return v;
  endfunction

  task automatic do_start(input int n, input logic [DW-1:0] init);
    in_count = n[CW-1:0];
    init_sum = init;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic feed(input vec_t v, output logic stalled);
    int  i = 0;
    int  g = 0;
    logic rdy;
    stalled = 1'b0;
    if (v.n > 0) begin
      in_valid = 1'b1;
      in_rank  = v.rank[0];
      in_deg   = v.deg[0];
      while (i < v.n && g < 5000) begin
        @(negedge clk);
        rdy = in_ready;
        if (!rdy) stalled = 1'b1;
        tick();
        if (rdy) begin
          i++;
          if (i < v.n) begin
            in_rank = v.rank[i];
            in_deg  = v.deg[i];
          end
        end
        g++;
      end
      in_valid = 1'b0;
      if (i < v.n) timeout("feed");
    end
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (!done && g < 2000) begin
      tick();
      g++;
    end
    if (!done) timeout(name);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t e, got;
    logic stalled;
    e.res = v.exp_res; e.ovf = v.exp_ovf; e.dang = v.exp_dang;
    sb.push_back(e);
    do_start(v.n, v.init);
    feed(v, stalled);
    wait_done({name, "_done"});
    @(negedge clk);
    got = sb.pop_front();
    chk({name, "_result"}, 64'(result), 64'(got.res));
    chk({name, "_overflow"}, 64'(overflow), 64'(got.ovf));
    chk({name, "_dangling"}, 64'(dangling_cnt), 64'(got.dang));
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_stall"}, 64'(stalled), 64'(v.exp_stall));
  endtask

  initial begin
    logic [63:0] acc;
    exp_t        got, e;
    vec_t        part;
    logic        st;

    // Job table
    vecs[0] = blank();
    vecs[0].n = 3;
    for (int i = 0; i < 3; i++) vecs[0].rank[i] = 32'h0001_0000;
    vecs[0].deg[0] = 1; vecs[0].deg[1] = 2; vecs[0].deg[2] = 4;
    vecs[0].exp_res = 32'h0001_C000;

    vecs[1] = blank();
    vecs[1].n = 2; vecs[1].init = 32'h100;
    vecs[1].rank[0] = 32'h0002_0000; vecs[1].deg[0] = 0;
    vecs[1].rank[1] = 32'h0002_0000; vecs[1].deg[1] = 2;
    vecs[1].exp_res = 32'h0001_0100; vecs[1].exp_dang = 1;

    vecs[2] = blank();
    vecs[2].n = 1; vecs[2].init = 32'hFFFF_FF00;
    vecs[2].rank[0] = 32'h0000_1000; vecs[2].deg[0] = 1;
    vecs[2].exp_res = 32'hFFFF_FFFF; vecs[2].exp_ovf = 1'b1;

    // 12 random pairs, one dangling; reference sum computed wide then saturated
    vecs[3] = blank();
    vecs[3].n = 12; vecs[3].init = 32'h0000_0123; vecs[3].exp_stall = 1'b1;
    acc = 64'(vecs[3].init);
    for (int i = 0; i < 12; i++) begin
      vecs[3].rank[i] = $urandom & 32'h0FFF_FFFF;
      vecs[3].deg[i]  = (i == 5) ? 32'd0 : 32'($urandom_range(1, 9));
      if (vecs[3].deg[i] != 0) acc += 64'(vecs[3].rank[i] / vecs[3].deg[i]);
      else vecs[3].exp_dang++;
    end
    vecs[3].exp_ovf = (acc > 64'hFFFF_FFFF);
    vecs[3].exp_res = vecs[3].exp_ovf ? 32'hFFFF_FFFF : acc[DW-1:0];

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_count = '0; init_sum = '0; in_rank = '0; in_deg = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_dangling", 64'(dangling_cnt), 64'd0);

    // Empty job: done appears on the third edge after start
    e.res = 32'h0000_1000; e.ovf = 1'b0; e.dang = 0;
    sb.push_back(e);
    tick();
    do_start(0, 32'h0000_1000);
    @(negedge clk);
    chk("empty_busy_load", 64'(busy), 64'd1);
    chk("empty_done_c1", 64'(done), 64'd0);
    tick();
    @(negedge clk);
    chk("empty_done_c2", 64'(done), 64'd0);
    tick();
    @(negedge clk);
    chk("empty_done_c3", 64'(done), 64'd1);
    got = sb.pop_front();
    chk("empty_result", 64'(result), 64'(got.res));

    for (int k = 0; k < 4; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
      tick();
    end

    // Reset in the middle of LOAD after two accepts
    part = vecs[0];
    part.n = 2;
    do_start(5, 32'h0);
    feed(part, st);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd0);
    chk("midrst_dangling", 64'(dangling_cnt), 64'd0);
    reset = 1'b0;
    tick();
    run_vec(vecs[0], "after_rst");
    run_vec(vecs[1], "after_rst2");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
